sw_accel_axil_regs: RTL and testbench
=====================================

# sw_accel_axil_regs

Synthesizable AXI4-Lite slave that exposes the banded Smith-Waterman accelerator to the PicoRV32 memory bus. It sits between the core's AXI memory port (after address decode) and `BandedSWAccelerator`. It holds the R/Q operand registers and generates the accelerator start pulse. It tracks busy/done, captures the aligned results, and returns them on reads.

## Interface
- `START_CYCLES`, default 2: number of cycles `acc_start` is held high per launch (range 1–15).
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_awvalid` in 1, `s_awready` out 1, `s_awaddr` in 32: write address channel.
- `s_wvalid` in 1, `s_wready` out 1, `s_wdata` in 32, `s_wstrb` in 4: write data channel.
- `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_arvalid` in 1, `s_arready` out 1, `s_araddr` in 32: read address channel.
- `s_rvalid` out 1, `s_rready` in 1, `s_rdata` out 32: read data channel.
- `acc_R`, `acc_Q`  out 24: operand registers, driven directly to the accelerator.
- `acc_start`  out 1: launch pulse.
- `acc_ready`  in 1: accelerator done level.
- `acc_R_aligned`, `acc_Q_aligned`  in 30: accelerator results.
- `irq_done`  out 1: one-cycle pulse when a result is captured.

## Operation
- Decode uses `addr[31:24]`; `addr[23:0]` is ignored.
  - 0x30 R (RW, bits 23:0)
  - 0x31 Q (RW, bits 23:0)
  - 0x32 STATUS (RO: bit0 done, bit1 busy, bit2 err)
  - 0x33 R_ALIGNED (RO, zero-extended)
  - 0x34 Q_ALIGNED (RO, zero-extended)
  - 0x35 CTRL (WO: bit0=1 launches, bit1=1 clears err)
- `wstrb` applies byte-wise to R and Q. CTRL acts only if `wstrb[0]` is set.
- Launch from IDLE or DONE:
  - clears done;
  - sets busy;
  - drives `acc_start` high for exactly START_CYCLES cycles;
  - enters RUN.
- In RUN, after `acc_start` has fallen, the first cycle with `acc_ready`=1:
  - captures both results into registers;
  - sets done and clears busy;
  - pulses `irq_done`;
  - enters DONE.
- `acc_ready` high during the start pulse is ignored, so a stale ready from the previous job cannot complete the new one.
- Error cases, each of which sets the sticky err flag:
  - a write to R, Q or CTRL-launch while busy is dropped;
  - a write to an unmapped address is dropped;
  - a read from an unmapped address returns 0.
- A write to a read-only register is dropped without setting err.
- FSM states are START, RUN, DONE; IDLE exists only out of reset.

## Timing
- Reset values of outputs:
  - `s_awready`, `s_wready`, `s_bvalid`, `s_arready`, `s_rvalid` are 0;
  - `s_rdata`, `acc_R`, `acc_Q` are 0;
  - `acc_start` and `irq_done` are 0;
  - STATUS is 0 and the result registers are 0.
- Write handshake:
  - When `s_awvalid && s_wvalid && !s_bvalid`, `s_awready` and `s_wready` pulse together for one cycle.
  - The register update happens on that edge.
  - `s_bvalid` rises the following cycle and is held until `s_bready`.
  - No new write is accepted while `s_bvalid` is high.
- Read handshake:
  - When `s_arvalid && !s_rvalid`, `s_arready` pulses for one cycle.
  - `s_rdata` and `s_rvalid` are valid the next cycle and held stable until `s_rready`.
- Both channels are independent. The read data reflects register state at the `s_arready` edge.
- A same-edge write to R with a read of R returns the old value.
- Launch latency:
  - `acc_start` rises the cycle after the CTRL write handshake.
  - busy is visible in STATUS from that same cycle.
- Completion: done, the captured results and `irq_done` all appear the cycle after the first qualifying `acc_ready`.
- A launch write on the same edge as the result capture is treated as busy: it is dropped and err is set.
- Reset mid-operation:
  - `acc_start` drops immediately (asynchronous);
  - an in-flight AXI response is discarded;
  - the FSM returns to IDLE.

## Structure
- A shared package `sw_accel_pkg` holds:
  - the address-decode byte constants (0x30–0x35);
  - the STATUS bit indices;
  - the FSM state enum;
  - the operand width (24) and result width (30).
- One natural sub-module is `sw_accel_launch_fsm`. It contains the state register, the start-pulse counter, ready qualification, result capture and the done/busy flags.
- The top level holds the AXI-Lite handshakes, the decoder and the operand registers.

## Test plan
- Write R=0x00A1B2C3 with `wstrb`=0xF, then read 0x3000_0000 → `s_rdata`=0x00A1B2C3. Write `wstrb`=0x1 with data 0xFF → read gives 0x00A1B2FF.
- Launch with START_CYCLES=2 → `acc_start` is high exactly 2 cycles. The model raises `acc_ready` with R_aligned=0x2AAAAAAA after 10 cycles → STATUS reads 0x1, R_ALIGNED reads 0x2AAAAAAA, and `irq_done` pulses once.
- Hold `acc_ready`=1 before launch → no completion until after `acc_start` falls; STATUS reads 0x2 during the pulse.
- While busy, write Q and CTRL=1 → Q is unchanged, STATUS bit2=1. Write CTRL=0x2 → err clears.
- Read 0x3600_0000 → data 0 and err set. Hold `s_bready`=0 for 5 cycles → `s_bvalid` stays high and a second write is not accepted.
- Assert `resetn`=0 mid-RUN → `acc_start`=0, STATUS reads 0 and R reads 0 after release.

Source files
------------

// File: rtl/sw_accel_pkg.sv
// Shared constants and types for the Smith-Waterman accelerator register block.
// Holds decode bytes, STATUS bit indices, FSM states, widths and a strobe helper.
package sw_accel_pkg;

    localparam int OP_W  = 24;
    localparam int RES_W = 30;

    localparam logic [7:0] ADDR_R     = 8'h30;
    localparam logic [7:0] ADDR_Q     = 8'h31;
    localparam logic [7:0] ADDR_STAT  = 8'h32;
    localparam logic [7:0] ADDR_R_AL  = 8'h33;
    localparam logic [7:0] ADDR_Q_AL  = 8'h34;
    localparam logic [7:0] ADDR_CTRL  = 8'h35;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [OP_W-1:0] apply_strb(
        input logic [OP_W-1:0] old,
        input logic [31:0]     data,
        input logic [3:0]      strb
    );
        logic [OP_W-1:0] v;
        v = old;
        for (int b = 0; b < OP_W / 8; b++) begin
            if (strb[b]) v[b*8 +: 8] = data[b*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/sw_accel_launch_fsm.sv
// Launch sequencer: start pulse, ready qualification, result capture, done/busy.
// Ports: launch in, acc_ready/results in; acc_start, irq_done, done, busy, results out.
module sw_accel_launch_fsm
    import sw_accel_pkg::*;
#(
    parameter int START_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             launch,
    input  logic             acc_ready,
    input  logic [RES_W-1:0] acc_R_aligned,
    input  logic [RES_W-1:0] acc_Q_aligned,
    output logic             acc_start,
    output logic             irq_done,
    output logic             done,
    output logic             busy,
    output logic [RES_W-1:0] r_res,
    output logic [RES_W-1:0] q_res
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       capture;

    // Ready is only looked at in RUN, i.e. after the start pulse has ended.
    assign capture = (state_q == S_RUN) && acc_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            irq_done <= 1'b0;
            r_res    <= '0;
            q_res    <= '0;
        end else begin
            cnt_q    <= (state_q == S_START) ? cnt_q + 4'd1 : 4'd0;
            irq_done <= capture;
            if (capture) begin
                r_res <= acc_R_aligned;
                q_res <= acc_Q_aligned;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (launch) state_d = S_START;
            S_START: begin
                if (cnt_q == 4'(START_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: if (acc_ready) state_d = S_DONE;
        endcase
    end

    always_comb begin
        acc_start = (state_q == S_START);
        busy      = (state_q == S_START) || (state_q == S_RUN);
        done      = (state_q == S_DONE);
    end

endmodule

// File: rtl/sw_accel_axil_regs.sv
// AXI4-Lite slave exposing the banded Smith-Waterman accelerator registers.
// Ports: AXI-Lite slave channels; acc_R/acc_Q/acc_start out; ready/results in; irq_done.
module sw_accel_axil_regs
    import sw_accel_pkg::*;
#(
    parameter int START_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_awvalid,
    output logic             s_awready,
    input  logic [31:0]      s_awaddr,
    input  logic             s_wvalid,
    output logic             s_wready,
    input  logic [31:0]      s_wdata,
    input  logic [3:0]       s_wstrb,
    output logic             s_bvalid,
    input  logic             s_bready,
    input  logic             s_arvalid,
    output logic             s_arready,
    input  logic [31:0]      s_araddr,
    output logic             s_rvalid,
    input  logic             s_rready,
    output logic [31:0]      s_rdata,
    output logic [OP_W-1:0]  acc_R,
    output logic [OP_W-1:0]  acc_Q,
    output logic             acc_start,
    input  logic             acc_ready,
    input  logic [RES_W-1:0] acc_R_aligned,
    input  logic [RES_W-1:0] acc_Q_aligned,
    output logic             irq_done
);

    logic             aw_go, ar_go, wr_fire, rd_fire;
    logic             done, busy, err;
    logic [RES_W-1:0] r_res, q_res;
    logic             r_we, q_we, launch, err_set, err_clr;
    logic [31:0]      rd_data, status;
    logic             rd_bad;
    logic             unused;

    assign unused = ^{s_awaddr[23:0], s_araddr[23:0]};

    // Ready pulses are registered, so the "not already ready" term keeps them one cycle.
    assign aw_go   = s_awvalid && s_wvalid && !s_bvalid && !s_awready;
    assign ar_go   = s_arvalid && !s_rvalid && !s_arready;
    assign wr_fire = s_awready && s_awvalid && s_wvalid;
    assign rd_fire = s_arready && s_arvalid;

    sw_accel_launch_fsm #(
        .START_CYCLES (START_CYCLES)
    ) u_fsm (
        .clk           (clk),
        .resetn        (resetn),
        .launch        (launch),
        .acc_ready     (acc_ready),
        .acc_R_aligned (acc_R_aligned),
        .acc_Q_aligned (acc_Q_aligned),
        .acc_start     (acc_start),
        .irq_done      (irq_done),
        .done          (done),
        .busy          (busy),
        .r_res         (r_res),
        .q_res         (q_res)
    );

    always_comb begin
        status            = '0;
        status[STAT_DONE] = done;
        status[STAT_BUSY] = busy;
        status[STAT_ERR]  = err;
    end

    always_comb begin
        rd_data = '0;
        rd_bad  = 1'b0;
        case (s_araddr[31:24])
            ADDR_R:    rd_data = {{(32-OP_W){1'b0}}, acc_R};
            ADDR_Q:    rd_data = {{(32-OP_W){1'b0}}, acc_Q};
            ADDR_STAT: rd_data = status;
            ADDR_R_AL: rd_data = {{(32-RES_W){1'b0}}, r_res};
            ADDR_Q_AL: rd_data = {{(32-RES_W){1'b0}}, q_res};
            default:   rd_bad  = 1'b1;
        endcase
    end

    // A launch on the capture edge still sees busy, so it is dropped here.
    always_comb begin
        r_we    = 1'b0;
        q_we    = 1'b0;
        launch  = 1'b0;
        err_set = rd_fire && rd_bad;
        err_clr = 1'b0;
        if (wr_fire) begin
            case (s_awaddr[31:24])
                ADDR_R: begin
                    if (busy) err_set = 1'b1;
                    else      r_we    = 1'b1;
                end
                ADDR_Q: begin
                    if (busy) err_set = 1'b1;
                    else      q_we    = 1'b1;
                end
                ADDR_CTRL: begin
                    if (s_wstrb[0]) begin
                        err_clr = s_wdata[1];
                        if (s_wdata[0]) begin
                            if (busy) err_set = 1'b1;
                            else      launch  = 1'b1;
                        end
                    end
                end
                ADDR_STAT, ADDR_R_AL, ADDR_Q_AL: ;
                default: err_set = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            acc_R     <= '0;
            acc_Q     <= '0;
            err       <= 1'b0;
        end else begin
            s_awready <= aw_go;
            s_wready  <= aw_go;
            s_arready <= ar_go;
            if (wr_fire)                s_bvalid <= 1'b1;
            else if (s_bready)          s_bvalid <= 1'b0;
            if (rd_fire) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_data;
            end else if (s_rready) begin
                s_rvalid <= 1'b0;
            end
            if (r_we) acc_R <= apply_strb(acc_R, s_wdata, s_wstrb);
            if (q_we) acc_Q <= apply_strb(acc_Q, s_wdata, s_wstrb);
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_accel_axil_regs.sv
// Directed bench for sw_accel_axil_regs: AXI-Lite access, launch, errors, reset.
// Expected values are hand-computed constants per scenario.
module tb_sw_accel_axil_regs;

    localparam logic [31:0] A_R    = 32'h3000_0000;
    localparam logic [31:0] A_Q    = 32'h3100_0000;
    localparam logic [31:0] A_STAT = 32'h3200_0000;
    localparam logic [31:0] A_RAL  = 32'h3300_0000;
    localparam logic [31:0] A_QAL  = 32'h3400_0000;
    localparam logic [31:0] A_CTRL = 32'h3500_0000;
    localparam logic [31:0] A_BAD  = 32'h3600_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_awvalid = 1'b0, s_awready;
    logic [31:0] s_awaddr = '0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_bvalid, s_bready = 1'b0;
    logic        s_arvalid = 1'b0, s_arready;
    logic [31:0] s_araddr = '0;
    logic        s_rvalid, s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [23:0] acc_R, acc_Q;
    logic        acc_start;
    logic        acc_ready = 1'b0;
    logic [29:0] acc_R_aligned = '0, acc_Q_aligned = '0;
    logic        irq_done;

    int vectors = 0;
    int miscompares = 0;
    int start_hi = 0;
    int irq_cnt = 0;

    sw_accel_axil_regs #(.START_CYCLES(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_awvalid     (s_awvalid),
        .s_awready     (s_awready),
        .s_awaddr      (s_awaddr),
        .s_wvalid      (s_wvalid),
        .s_wready      (s_wready),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_bvalid      (s_bvalid),
        .s_bready      (s_bready),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .s_araddr      (s_araddr),
        .s_rvalid      (s_rvalid),
        .s_rready      (s_rready),
        .s_rdata       (s_rdata),
        .acc_R         (acc_R),
        .acc_Q         (acc_Q),
        .acc_start     (acc_start),
        .acc_ready     (acc_ready),
        .acc_R_aligned (acc_R_aligned),
        .acc_Q_aligned (acc_Q_aligned),
        .irq_done      (irq_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (acc_start) start_hi++;
        if (irq_done)  irq_cnt++;
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_awready && n < 20);
        vectors++;
        if (!s_awready) begin
            miscompares++;
            $display("FAIL wr_awready_timeout addr=%h: got 0 want 1", a);
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (!s_bvalid) begin
            miscompares++;
            $display("FAIL wr_bvalid_timeout addr=%h: got 0 want 1", a);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_arready && n < 20);
        vectors++;
        if (!s_arready) begin
            miscompares++;
            $display("FAIL rd_arready_timeout addr=%h: got 0 want 1", a);
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (!s_rvalid) begin
            miscompares++;
            $display("FAIL rd_rvalid_timeout addr=%h: got 0 want 1", a);
        end
        d = s_rdata;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
             acc_start, irq_done} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                      acc_start, irq_done});
        end
        vectors++;
        if ({s_rdata, acc_R, acc_Q} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h want 0", s_rdata, acc_R, acc_Q);
        end
        resetn = 1'b1;
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status: got %h want 00000000", d);
        end
        axi_read(A_RAL, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_raligned: got %h want 00000000", d);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        axi_write(A_R, 32'h00A1_B2C3, 4'hF);
        axi_read(A_R, d);
        vectors++;
        if (d !== 32'h00A1_B2C3) begin
            miscompares++;
            $display("FAIL r_full: got %h want 00a1b2c3", d);
        end
        axi_write(A_R, 32'h0000_00FF, 4'h1);
        axi_read(A_R, d);
        vectors++;
        if (d !== 32'h00A1_B2FF || acc_R !== 24'hA1_B2FF) begin
            miscompares++;
            $display("FAIL r_strb1: got %h/%h want 00a1b2ff", d, acc_R);
        end
        axi_write(A_R, 32'hEE00_0000, 4'h8);
        axi_read(A_R, d);
        vectors++;
        if (d !== 32'h00A1_B2FF) begin
            miscompares++;
            $display("FAIL r_strb8: got %h want 00a1b2ff", d);
        end
        axi_write(A_Q, 32'h1165_4321, 4'h6);
        axi_read(A_Q, d);
        vectors++;
        if (d !== 32'h0065_4300 || acc_Q !== 24'h65_4300) begin
            miscompares++;
            $display("FAIL q_strb6: got %h/%h want 00654300", d, acc_Q);
        end
    endtask

    task automatic test_launch();
        logic [31:0] d;
        int s0, i0;
        s0 = start_hi; i0 = irq_cnt;
        acc_ready = 1'b0;
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (10) @(negedge clk);
        acc_R_aligned = 30'h2AAA_AAAA;
        acc_Q_aligned = 30'h1555_5555;
        acc_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (irq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL launch_irq: got %b want 1", irq_done);
        end
        acc_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (irq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL launch_irq_fall: got %b want 0", irq_done);
        end
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL launch_status: got %h want 00000001", d);
        end
        axi_read(A_RAL, d);
        vectors++;
        if (d !== 32'h2AAA_AAAA) begin
            miscompares++;
            $display("FAIL launch_raligned: got %h want 2aaaaaaa", d);
        end
        axi_read(A_QAL, d);
        vectors++;
        if (d !== 32'h1555_5555) begin
            miscompares++;
            $display("FAIL launch_qaligned: got %h want 15555555", d);
        end
        vectors++;
        if (start_hi - s0 !== 2 || irq_cnt - i0 !== 1) begin
            miscompares++;
            $display("FAIL launch_counts: got start=%0d irq=%0d want 2 1",
                     start_hi - s0, irq_cnt - i0);
        end
    endtask

    task automatic test_stale_ready();
        logic [31:0] d;
        acc_R_aligned = 30'h0ABC_DEF0;
        @(negedge clk);
        s_awaddr = A_CTRL; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        acc_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_awready !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_awready: got %b want 1", s_awready);
        end
        s_araddr = A_STAT; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({acc_start, irq_done, s_arready} !== 3'b101) begin
            miscompares++;
            $display("FAIL stale_pulse1: got %b want 101",
                     {acc_start, irq_done, s_arready});
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({acc_start, irq_done, s_rvalid} !== 3'b101 || s_rdata !== 32'h2) begin
            miscompares++;
            $display("FAIL stale_pulse2: got %b rdata=%h want 101 00000002",
                     {acc_start, irq_done, s_rvalid}, s_rdata);
        end
        s_rready = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0; s_bready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({acc_start, irq_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL stale_run: got %b want 00", {acc_start, irq_done});
        end
        @(negedge clk);
        vectors++;
        if (irq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_irq: got %b want 1", irq_done);
        end
        acc_ready = 1'b0;
        axi_read(A_RAL, d);
        vectors++;
        if (d !== 32'h0ABC_DEF0) begin
            miscompares++;
            $display("FAIL stale_raligned: got %h want 0abcdef0", d);
        end
    endtask

    task automatic test_busy_err();
        logic [31:0] d;
        acc_ready = 1'b0;
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_Q, 32'h0012_3456, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_read(A_Q, d);
        vectors++;
        if (d !== 32'h0065_4300) begin
            miscompares++;
            $display("FAIL busy_q_kept: got %h want 00654300", d);
        end
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h6) begin
            miscompares++;
            $display("FAIL busy_status: got %h want 00000006", d);
        end
        axi_write(A_CTRL, 32'h2, 4'hF);
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL busy_errclr: got %h want 00000002", d);
        end
        @(negedge clk); acc_ready = 1'b1;
        @(negedge clk); acc_ready = 1'b0;
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL busy_done: got %h want 00000001", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        axi_read(A_BAD, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL bad_rdata: got %h want 00000000", d);
        end
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h5) begin
            miscompares++;
            $display("FAIL bad_rd_err: got %h want 00000005", d);
        end
        axi_write(A_CTRL, 32'h2, 4'hF);
        axi_write(A_STAT, 32'h7, 4'hF);
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL ro_write: got %h want 00000001", d);
        end
        axi_write(32'h4000_0000, 32'h1, 4'hF);
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h5) begin
            miscompares++;
            $display("FAIL bad_wr_err: got %h want 00000005", d);
        end
        axi_write(A_CTRL, 32'h2, 4'hF);
    endtask

    task automatic test_bready_hold();
        logic [31:0] d;
        int n;
        @(negedge clk);
        s_awaddr = A_R; s_wdata = 32'h0011_1111; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_awready && n < 20);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (s_bvalid !== 1'b1 || s_awready !== 1'b0) begin
                miscompares++;
                $display("FAIL bhold_%0d: got bvalid=%b awready=%b want 1 0",
                         i, s_bvalid, s_awready);
            end
            s_wdata = 32'h0022_2222;
            s_awvalid = 1'b1; s_wvalid = 1'b1;
        end
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        axi_read(A_R, d);
        vectors++;
        if (d !== 32'h0011_1111) begin
            miscompares++;
            $display("FAIL bhold_r: got %h want 00111111", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n;
        acc_ready = 1'b0;
        @(negedge clk);
        s_awaddr = A_CTRL; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_awready && n < 20);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1;
        vectors++;
        if ({acc_start, s_bvalid} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_pre: got %b want 11", {acc_start, s_bvalid});
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({acc_start, s_bvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_async: got %b want 00", {acc_start, s_bvalid});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        axi_read(A_STAT, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_status: got %h want 00000000", d);
        end
        axi_read(A_R, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_r: got %h want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_launch();
        test_stale_ready();
        test_busy_err();
        test_unmapped();
        test_bready_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
